// File: rtl/dot_product_pkg.sv
// Shared widths and phase type for the serial dot-product engine and its transmitter.
// The engine and transmitter both count phases 0..FRAME_LEN-1 from reset.
package dot_product_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int VECTOR_SIZE  = 3;
  localparam int FRAME_LEN    = 2 * VECTOR_SIZE;
  localparam int RESULT_WIDTH = 2 * DATA_WIDTH + 2;
  localparam int PHASE_W      = $clog2(FRAME_LEN);
  localparam int VEC_W        = VECTOR_SIZE * DATA_WIDTH;

  typedef logic [PHASE_W-1:0]    phase_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [VEC_W-1:0]      vec_t;

  localparam phase_t PH_LAST = phase_t'(FRAME_LEN - 1);

  function automatic phase_t next_phase(input phase_t ph);
    return (ph == PH_LAST) ? '0 : ph + phase_t'(1);
  endfunction

endpackage

// File: rtl/dot_product_frame_buf.sv
// Holding and active frame-word registers; the frame word at i_idx is read combinationally.
// Load and launch take effect at the clock edge; the read path adds no latency.
module dot_product_frame_buf
  import dot_product_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_load,
  input  logic [VEC_W-1:0]      i_a,
  input  logic [VEC_W-1:0]      i_b,
  input  logic                  i_launch,
  input  logic [PHASE_W-1:0]    i_idx,
  input  logic                  i_from_hold,
  output logic [DATA_WIDTH-1:0] o_word
);

  // Stored in frame order: A0..A(N-1) then B0..B(N-1).
  word_t r_hold [FRAME_LEN];
  word_t r_act  [FRAME_LEN];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        r_hold[k] <= '0;
        r_act[k]  <= '0;
      end
    end else begin
      if (i_load) begin
        for (int i = 0; i < VECTOR_SIZE; i++) begin
          r_hold[i]               <= i_a[i*DATA_WIDTH +: DATA_WIDTH];
          r_hold[VECTOR_SIZE + i] <= i_b[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (i_launch) begin
        for (int k = 0; k < FRAME_LEN; k++) begin
          r_act[k] <= r_hold[k];
        end
      end
    end
  end

  assign o_word = i_from_hold ? r_hold[i_idx] : r_act[i_idx];

endmodule

// File: rtl/dot_product_tx.sv
// Serializes operand pairs into engine frames, captures each result one cycle into the next frame.
// Accept-to-result latency 13 cycles; in_ready drops while the single holding slot is occupied.
module dot_product_tx
  import dot_product_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [VEC_W-1:0]        in_a,
  input  logic [VEC_W-1:0]        in_b,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_sof,
  output logic                    tx_active,
  input  logic                    eng_run,
  input  logic [RESULT_WIDTH-1:0] eng_result,
  output logic                    res_valid,
  output logic [RESULT_WIDTH-1:0] res_data,
  output logic                    sync_err
);

  phase_t                  r_ph;
  logic                    r_hold_full;
  logic                    r_frame_active;
  logic                    r_cap_due;
  word_t                   r_tx_data;
  logic                    r_res_valid;
  logic [RESULT_WIDTH-1:0] r_res_data;
  logic                    r_sync_err;

  logic   w_accept;
  logic   w_wrap;
  logic   w_launch;
  phase_t w_next_ph;
  word_t  w_word;
  word_t  w_tx_next;

  assign w_accept  = in_valid && !r_hold_full;
  assign w_wrap    = (r_ph == PH_LAST);
  assign w_launch  = w_wrap && r_hold_full;
  assign w_next_ph = next_phase(r_ph);

  dot_product_frame_buf u_frame_buf (
    .clk         (clk),
    .resetn      (resetn),
    .i_load      (w_accept),
    .i_a         (in_a),
    .i_b         (in_b),
    .i_launch    (w_launch),
    .i_idx       (w_next_ph),
    .i_from_hold (w_wrap),
    .o_word      (w_word)
  );

  // Word 0 of a new frame comes straight from the holding slot, because the
  // active registers are only loaded by the same edge that registers it.
  always_comb begin
    w_tx_next = '0;
    if (w_wrap) begin
      if (r_hold_full) w_tx_next = w_word;
    end else if (r_frame_active) begin
      w_tx_next = w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ph           <= '0;
      r_hold_full    <= 1'b0;
      r_frame_active <= 1'b0;
      r_tx_data      <= '0;
    end else begin
      r_ph      <= w_next_ph;
      r_tx_data <= w_tx_next;
      if (w_accept) begin
        r_hold_full <= 1'b1;
      end else if (w_launch) begin
        r_hold_full <= 1'b0;
      end
      if (w_wrap) r_frame_active <= r_hold_full;
    end
  end

  // The engine presents a frame's result during phase 0 of the following frame.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cap_due   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_wrap) begin
        r_cap_due <= r_frame_active;
      end else if ((r_ph == '0) && r_cap_due) begin
        r_res_data  <= eng_result;
        r_res_valid <= 1'b1;
        r_cap_due   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync_err <= 1'b0;
    end else if (eng_run != (r_ph == '0)) begin
      r_sync_err <= 1'b1;
    end
  end

  assign in_ready  = !r_hold_full;
  assign tx_data   = r_tx_data;
  assign tx_sof    = r_frame_active && (r_ph == '0);
  assign tx_active = r_frame_active;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_dot_product_tx.sv
// Bench for dot_product_tx with a behavioural serial engine and a cycle-indexed frame schedule model.
module tb_dot_product_tx;
  import dot_product_pkg::*;

  localparam int MAXC = 512;

  logic                    clk;
  logic                    resetn;
  logic                    in_valid;
  logic                    in_ready;
  logic [VEC_W-1:0]        in_a;
  logic [VEC_W-1:0]        in_b;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_sof;
  logic                    tx_active;
  logic                    eng_run;
  logic [RESULT_WIDTH-1:0] eng_result;
  logic                    res_valid;
  logic [RESULT_WIDTH-1:0] res_data;
  logic                    sync_err;

  int n_chk  = 0;
  int n_pass = 0;

  dot_product_tx dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .tx_data    (tx_data),
    .tx_sof     (tx_sof),
    .tx_active  (tx_active),
    .eng_run    (eng_run),
    .eng_result (eng_result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural engine: collects one frame of words, presents the dot product during the next frame.
  int                      eng_ph;
  logic [DATA_WIDTH-1:0]   eng_w [FRAME_LEN];
  logic [RESULT_WIDTH-1:0] eng_res;
  logic                    kill_run;

  always @(posedge clk) begin
    if (!resetn) begin
      eng_ph  <= 0;
      eng_res <= '0;
    end else begin
      eng_w[eng_ph] <= tx_data;
      if (eng_ph == FRAME_LEN - 1) begin
        eng_res <= RESULT_WIDTH'(eng_w[0]) * RESULT_WIDTH'(eng_w[3])
                 + RESULT_WIDTH'(eng_w[1]) * RESULT_WIDTH'(eng_w[4])
                 + RESULT_WIDTH'(eng_w[2]) * RESULT_WIDTH'(tx_data);
        eng_ph  <= 0;
      end else begin
        eng_ph <= eng_ph + 1;
      end
    end
  end

  assign eng_run    = (eng_ph == 0) && !kill_run;
  assign eng_result = eng_res;

  function automatic logic [RESULT_WIDTH-1:0] dot_ref(input vec_t a, input vec_t b);
    int s;
    s = 0;
    for (int i = 0; i < VECTOR_SIZE; i++)
      s += int'(a[i*DATA_WIDTH +: DATA_WIDTH]) * int'(b[i*DATA_WIDTH +: DATA_WIDTH]);
    return RESULT_WIDTH'(s);
  endfunction

  function automatic vec_t pack3(input int e0, input int e1, input int e2);
    return {word_t'(e2), word_t'(e1), word_t'(e0)};
  endfunction

  // Returns mid-cycle in the first cycle after reset (phase 0).
  task automatic do_reset();
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    kill_run = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  vec_t q_a[$];
  vec_t q_b[$];

  word_t                   e_word [MAXC];
  bit                      e_act  [MAXC];
  bit                      e_sof  [MAXC];
  bit                      e_rv   [MAXC];
  logic [RESULT_WIDTH-1:0] e_rd   [MAXC];

  task automatic test_reset();
    do_reset();
    n_chk++; if (tx_data !== '0)   $display("FAIL reset tx_data got %0h want 0", tx_data);     else n_pass++;
    n_chk++; if (tx_sof !== 1'b0)  $display("FAIL reset tx_sof got %0b want 0", tx_sof);       else n_pass++;
    n_chk++; if (tx_active !== 1'b0) $display("FAIL reset tx_active got %0b want 0", tx_active); else n_pass++;
    n_chk++; if (res_valid !== 1'b0) $display("FAIL reset res_valid got %0b want 0", res_valid); else n_pass++;
    n_chk++; if (res_data !== '0)  $display("FAIL reset res_data got %0d want 0", res_data);   else n_pass++;
    n_chk++; if (sync_err !== 1'b0) $display("FAIL reset sync_err got %0b want 0", sync_err);  else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset in_ready got %0b want 1", in_ready);  else n_pass++;
  endtask

  // Single pair accepted in cycle 0: words in cycles 6..11, result pulse in cycle 13.
  task automatic test_basic();
    word_t exp_tx;
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      exp_tx = word_t'((c >= 6 && c <= 11) ? c - 5 : 0);
      n_chk++; if (tx_data !== exp_tx) $display("FAIL basic tx_data cyc %0d got %0d want %0d", c, tx_data, exp_tx); else n_pass++;
      n_chk++; if (tx_sof !== (c == 6)) $display("FAIL basic tx_sof cyc %0d got %0b want %0b", c, tx_sof, c == 6); else n_pass++;
      n_chk++; if (in_ready !== (c == 0 || c >= 6)) $display("FAIL basic in_ready cyc %0d got %0b", c, in_ready); else n_pass++;
      n_chk++; if (res_valid !== (c == 13)) $display("FAIL basic res_valid cyc %0d got %0b want %0b", c, res_valid, c == 13); else n_pass++;
      if (c == 13) begin
        n_chk++; if (res_data !== 18'd32) $display("FAIL basic res_data got %0d want 32", res_data); else n_pass++;
      end
      in_valid = (c == 0);
      in_a     = pack3(1, 2, 3);
      in_b     = pack3(4, 5, 6);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Drains q_a/q_b starting from phase 0; expectations come from the frame schedule:
  // a pair held before the cycle ahead of a phase-0 boundary is sent from that boundary,
  // and its result pulses FRAME_LEN+1 cycles after the frame's first word.
  task automatic test_stream(input string name, input int gap_pct);
    bit                      pending;
    int                      acc_cyc;
    int                      last_sched;
    int                      cyc;
    vec_t                    hold_a, hold_b;
    logic [RESULT_WIDTH-1:0] exp_res;
    for (int i = 0; i < MAXC; i++) begin
      e_word[i] = '0; e_act[i] = 1'b0; e_sof[i] = 1'b0; e_rv[i] = 1'b0; e_rd[i] = '0;
    end
    pending = 1'b0; acc_cyc = 0; last_sched = 0; cyc = 0; exp_res = '0;
    hold_a = '0; hold_b = '0;
    while ((q_a.size() != 0 || pending || cyc <= last_sched + 1) && cyc < MAXC - 2*FRAME_LEN) begin
      if ((cyc % FRAME_LEN == 0) && pending && acc_cyc <= cyc - 2) begin
        for (int k = 0; k < FRAME_LEN; k++) begin
          e_word[cyc+k] = (k < VECTOR_SIZE) ? hold_a[k*DATA_WIDTH +: DATA_WIDTH]
                                            : hold_b[(k-VECTOR_SIZE)*DATA_WIDTH +: DATA_WIDTH];
          e_act[cyc+k]  = 1'b1;
        end
        e_sof[cyc]             = 1'b1;
        e_rv[cyc+FRAME_LEN+1]  = 1'b1;
        e_rd[cyc+FRAME_LEN+1]  = dot_ref(hold_a, hold_b);
        last_sched             = cyc + FRAME_LEN + 1;
        pending                = 1'b0;
      end
      if (e_rv[cyc]) exp_res = e_rd[cyc];
      n_chk++; if (tx_data !== e_word[cyc]) $display("FAIL %s tx_data cyc %0d got %0d want %0d", name, cyc, tx_data, e_word[cyc]); else n_pass++;
      n_chk++; if (tx_active !== e_act[cyc]) $display("FAIL %s tx_active cyc %0d got %0b want %0b", name, cyc, tx_active, e_act[cyc]); else n_pass++;
      n_chk++; if (tx_sof !== e_sof[cyc]) $display("FAIL %s tx_sof cyc %0d got %0b want %0b", name, cyc, tx_sof, e_sof[cyc]); else n_pass++;
      n_chk++; if (res_valid !== e_rv[cyc]) $display("FAIL %s res_valid cyc %0d got %0b want %0b", name, cyc, res_valid, e_rv[cyc]); else n_pass++;
      n_chk++; if (res_data !== exp_res) $display("FAIL %s res_data cyc %0d got %0d want %0d", name, cyc, res_data, exp_res); else n_pass++;
      n_chk++; if (in_ready !== !pending) $display("FAIL %s in_ready cyc %0d got %0b want %0b", name, cyc, in_ready, !pending); else n_pass++;
      n_chk++; if (sync_err !== 1'b0) $display("FAIL %s sync_err cyc %0d got %0b want 0", name, cyc, sync_err); else n_pass++;
      if (q_a.size() != 0 && int'($urandom_range(99)) >= gap_pct) begin
        in_valid = 1'b1;
        in_a     = q_a[0];
        in_b     = q_b[0];
        if (!pending) begin
          hold_a  = q_a.pop_front();
          hold_b  = q_b.pop_front();
          pending = 1'b1;
          acc_cyc = cyc;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_chk++; if (q_a.size() != 0 || pending) $display("FAIL %s drain cycle budget expired with %0d pairs left", name, q_a.size()); else n_pass++;
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 30; c++) begin
      n_chk++; if (tx_data !== '0) $display("FAIL idle tx_data cyc %0d got %0d want 0", c, tx_data); else n_pass++;
      n_chk++; if (tx_active !== 1'b0) $display("FAIL idle tx_active cyc %0d got %0b want 0", c, tx_active); else n_pass++;
      n_chk++; if (res_valid !== 1'b0) $display("FAIL idle res_valid cyc %0d got %0b want 0", c, res_valid); else n_pass++;
      n_chk++; if (sync_err !== 1'b0) $display("FAIL idle sync_err cyc %0d got %0b want 0", c, sync_err); else n_pass++;
      @(negedge clk);
    end
  endtask

  // eng_run held low across the edge ending phase-0 cycle 6.
  task automatic test_sync_err();
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      n_chk++; if (sync_err !== (c >= 7)) $display("FAIL sync sync_err cyc %0d got %0b want %0b", c, sync_err, c >= 7); else n_pass++;
      kill_run = (c == 6);
      @(negedge clk);
    end
    kill_run = 1'b0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      n_chk++; if (sync_err !== 1'b0) $display("FAIL sync after reset cyc %0d got %0b want 0", c, sync_err); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      in_valid = (c == 0);
      in_a     = pack3(7, 8, 9);
      in_b     = pack3(1, 2, 3);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++; if (tx_data !== 8'd1) $display("FAIL midrst word3 got %0d want 1", tx_data); else n_pass++;
    n_chk++; if (tx_active !== 1'b1) $display("FAIL midrst active got %0b want 1", tx_active); else n_pass++;
    resetn = 1'b0;
    @(negedge clk);
    n_chk++; if (tx_data !== '0) $display("FAIL midrst tx_data got %0d want 0", tx_data); else n_pass++;
    n_chk++; if (tx_active !== 1'b0) $display("FAIL midrst tx_active got %0b want 0", tx_active); else n_pass++;
    n_chk++; if (tx_sof !== 1'b0) $display("FAIL midrst tx_sof got %0b want 0", tx_sof); else n_pass++;
    n_chk++; if (res_valid !== 1'b0) $display("FAIL midrst res_valid got %0b want 0", res_valid); else n_pass++;
    n_chk++; if (res_data !== '0) $display("FAIL midrst res_data got %0d want 0", res_data); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL midrst in_ready got %0b want 1", in_ready); else n_pass++;
    resetn = 1'b1;
    q_a.push_back(pack3(2, 3, 4));
    q_b.push_back(pack3(5, 6, 7));
    test_stream("after_reset", 0);
  endtask

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    kill_run = 1'b0;

    test_reset();
    test_basic();

    do_reset();
    q_a.push_back('1); q_b.push_back('1);
    q_a.push_back('1); q_b.push_back('1);
    test_stream("max", 0);

    do_reset();
    q_a.push_back(pack3(1, 1, 1)); q_b.push_back(pack3(1, 1, 1));
    q_a.push_back(pack3(2, 0, 0)); q_b.push_back(pack3(3, 0, 0));
    test_stream("back_to_back", 0);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      q_a.push_back(vec_t'($urandom()));
      q_b.push_back(vec_t'($urandom()));
    end
    test_stream("random", 35);

    test_idle();
    test_sync_err();
    test_reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
